// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial add/subtract sequencer driving one shared external
// full-adder cell, LSB first. A result is ready WIDTH cycles after the accept edge
// and is held on a valid/ready handshake until the consumer takes it.
// Ports:
//   CLK, RST                  clock and async active-high reset
//   START, A_IN, B_IN, SUB,   request (accepted when IN_READY=1), operands,
//   CI_IN, IN_READY           subtract select, carry-in, idle indicator
//   ABORT                     synchronous abort of the operation in RUN or DONE
//   FA_A, FA_B, FA_CI         inputs of the shared full adder (register-driven)
//   FA_S, FA_CO               outputs of the shared full adder
//   RES_VALID, RES_READY      result handshake
//   SUM, CO_OUT, OVF          result, carry out of the MSB, signed overflow
//   BUSY                      high while bits are being processed
module serial_add_seq #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A_IN,
  input  logic [WIDTH-1:0] B_IN,
  input  logic             SUB,
  input  logic             CI_IN,
  input  logic             ABORT,
  output logic             IN_READY,
  output logic             FA_A,
  output logic             FA_B,
  output logic             FA_CI,
  input  logic             FA_S,
  input  logic             FA_CO,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             CO_OUT,
  output logic             OVF,
  output logic             BUSY
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_shift;
  logic             carry;
  logic             co_q;
  logic             ovf_q;
  logic [CW-1:0]    cnt;
  logic             last_bit;

  assign last_bit = (cnt == CW'(WIDTH - 1));

  // New sum bit enters at the MSB; the oldest bit drops off the bottom.
  assign sum_shift = WIDTH'({FA_S, sum_sh} >> 1);

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and outputs. ABORT wins over completion and over RES_READY.
  always_comb begin
    state_nxt = state;
    IN_READY  = 1'b0;
    BUSY      = 1'b0;
    RES_VALID = 1'b0;
    FA_A      = 1'b0;
    FA_B      = 1'b0;
    FA_CI     = 1'b0;
    case (state)
      IDLE: begin
        IN_READY = 1'b1;
        if (START) state_nxt = RUN;
      end
      RUN: begin
        BUSY  = 1'b1;
        // Adder inputs come straight from registers: no path from FA_S/FA_CO.
        FA_A  = a_sh[0];
        FA_B  = b_sh[0];
        FA_CI = carry;
        if (ABORT)         state_nxt = IDLE;
        else if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        RES_VALID = 1'b1;
        if (ABORT || RES_READY) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath. The result registers are separate from the working shift
  // register so SUM/CO_OUT/OVF stay put while a new operation is running.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      co_q   <= 1'b0;
      ovf_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            a_sh  <= A_IN;
            // Subtract as A + ~B + 1: invert B and fold the +1 into the carry.
            b_sh  <= SUB ? ~B_IN : B_IN;
            carry <= CI_IN ^ SUB;
            cnt   <= '0;
          end
        end
        RUN: begin
          if (!ABORT) begin
            sum_sh <= sum_shift;
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            carry  <= FA_CO;
            if (last_bit) begin
              sum_q <= sum_shift;
              co_q  <= FA_CO;
              // carry here is the carry into the MSB.
              ovf_q <= carry ^ FA_CO;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign SUM    = sum_q;
  assign CO_OUT = co_q;
  assign OVF    = ovf_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq at WIDTH=8 with a behavioural full adder
// wired to the FA_* ports. Inputs change and outputs are sampled on the falling edge.
module tb_serial_add_seq;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic         START;
  logic [W-1:0] A_IN;
  logic [W-1:0] B_IN;
  logic         SUB;
  logic         CI_IN;
  logic         ABORT;
  logic         IN_READY;
  logic         FA_A;
  logic         FA_B;
  logic         FA_CI;
  logic         FA_S;
  logic         FA_CO;
  logic         RES_VALID;
  logic         RES_READY;
  logic [W-1:0] SUM;
  logic         CO_OUT;
  logic         OVF;
  logic         BUSY;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  // Full-adder cell model.
  assign FA_S  = FA_A ^ FA_B ^ FA_CI;
  assign FA_CO = (FA_A & FA_B) | (FA_CI & (FA_A ^ FA_B));

  serial_add_seq #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .A_IN(A_IN), .B_IN(B_IN),
    .SUB(SUB), .CI_IN(CI_IN), .ABORT(ABORT), .IN_READY(IN_READY),
    .FA_A(FA_A), .FA_B(FA_B), .FA_CI(FA_CI), .FA_S(FA_S), .FA_CO(FA_CO),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .SUM(SUM),
    .CO_OUT(CO_OUT), .OVF(OVF), .BUSY(BUSY)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge while idle; returns at the first falling edge after accept.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic ci);
    A_IN  = a;
    B_IN  = b;
    SUB   = sub;
    CI_IN = ci;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  // edges: rising edges after the accept edge until RES_VALID is seen (-1 on timeout).
  task automatic wait_result(output int edges, output int busy_n);
    edges  = 0;
    busy_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (RES_VALID) break;
      if (BUSY) busy_n++;
      @(negedge CLK);
      edges++;
    end
    if (!RES_VALID) edges = -1;
  endtask

  task automatic finish_op(input string tag);
    RES_READY = 1'b1;
    @(negedge CLK);
    RES_READY = 1'b0;
    check({tag, "_valid_clr"}, RES_VALID, 0);
    check({tag, "_idle"}, IN_READY, 1);
  endtask

  int  edges;
  int  busy_n;
  bit  seen;

  initial begin
    RST = 1'b1; START = 1'b0; A_IN = '0; B_IN = '0; SUB = 1'b0;
    CI_IN = 1'b0; ABORT = 1'b0; RES_READY = 1'b0;
    #1;
    check("rst_in_ready", IN_READY, 1);
    check("rst_valid", RES_VALID, 0);
    check("rst_busy", BUSY, 0);
    check("rst_sum", SUM, 8'h00);
    check("rst_fa", {FA_A, FA_B, FA_CI}, 3'b000);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // Add 0x5A + 0x3C = 0x96, signed overflow.
    start_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    wait_result(edges, busy_n);
    check("add_latency", edges, 8);
    check("add_busy_cycles", busy_n, 8);
    check("add_sum", SUM, 8'h96);
    check("add_co", CO_OUT, 0);
    check("add_ovf", OVF, 1);
    check("add_fa_done", {FA_A, FA_B, FA_CI}, 3'b000);
    finish_op("add");

    // Reset in the middle of 0x12 + 0x34.
    start_op(8'h12, 8'h34, 1'b0, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("midrst_in_ready", IN_READY, 1);
    check("midrst_valid", RES_VALID, 0);
    check("midrst_sum", SUM, 8'h00);
    check("midrst_busy", BUSY, 0);
    check("midrst_fa", {FA_A, FA_B, FA_CI}, 3'b000);
    @(negedge CLK);
    RST = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (RES_VALID) seen = 1'b1;
    end
    check("midrst_no_result", seen, 0);

    // Subtract 0x10 - 0x20: first bit sees ~B[0]=1 and carry=1.
    start_op(8'h10, 8'h20, 1'b1, 1'b0);
    check("sub1_fa_bit0", {FA_A, FA_B, FA_CI}, 3'b011);
    wait_result(edges, busy_n);
    check("sub1_latency", edges, 8);
    check("sub1_sum", SUM, 8'hF0);
    check("sub1_co", CO_OUT, 0);
    check("sub1_ovf", OVF, 0);
    finish_op("sub1");

    // Subtract 0x80 - 0x01: wraps to 0x7F, no borrow, overflow.
    start_op(8'h80, 8'h01, 1'b1, 1'b0);
    wait_result(edges, busy_n);
    check("sub2_latency", edges, 8);
    check("sub2_sum", SUM, 8'h7F);
    check("sub2_co", CO_OUT, 1);
    check("sub2_ovf", OVF, 1);
    finish_op("sub2");

    // 0xFF + 0x00 + carry-in wraps to 0.
    start_op(8'hFF, 8'h00, 1'b0, 1'b1);
    wait_result(edges, busy_n);
    check("wrap_sum", SUM, 8'h00);
    check("wrap_co", CO_OUT, 1);
    check("wrap_ovf", OVF, 0);
    finish_op("wrap");

    // Backpressure: result held 5 cycles while START is pushed.
    start_op(8'h21, 8'h13, 1'b0, 1'b0);
    wait_result(edges, busy_n);
    check("bp_latency", edges, 8);
    A_IN = 8'hAA; B_IN = 8'h55; START = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("bp_sum_hold", SUM, 8'h34);
      check("bp_valid_hold", RES_VALID, 1);
      check("bp_not_ready", IN_READY, 0);
    end
    START = 1'b0;
    RES_READY = 1'b1;
    @(negedge CLK);
    RES_READY = 1'b0;
    check("bp_idle_after_hs", IN_READY, 1);
    check("bp_valid_clr", RES_VALID, 0);
    check("bp_sum_kept", SUM, 8'h34);
    start_op(8'h03, 8'h04, 1'b0, 1'b0);
    check("bp_next_accepted", BUSY, 1);
    wait_result(edges, busy_n);
    check("bp_next_sum", SUM, 8'h07);
    finish_op("bp_next");

    // Abort at RUN bit 3 of a carry-heavy op, then a clean 0x01 + 0x01.
    start_op(8'hFF, 8'h01, 1'b0, 1'b1);
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    check("abort_idle", IN_READY, 1);
    check("abort_no_valid", RES_VALID, 0);
    check("abort_busy", BUSY, 0);
    check("abort_fa", {FA_A, FA_B, FA_CI}, 3'b000);
    start_op(8'h01, 8'h01, 1'b0, 1'b0);
    wait_result(edges, busy_n);
    check("post_abort_latency", edges, 8);
    check("post_abort_sum", SUM, 8'h02);
    check("post_abort_co", CO_OUT, 0);
    check("post_abort_ovf", OVF, 0);
    finish_op("post_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
